mem_store_monitor: RTL

//  Sits directly downstream of the single-cycle MIPS top, on its data-memory write bus (memwrite/dataadr/writedata).

---
 rtl/mem_store_monitor_pkg.sv | 25 ++
 rtl/mem_store_monitor_if.sv | 30 +++
 rtl/mem_store_monitor_fifo.sv | 58 +++++
 rtl/mem_store_monitor.sv | 101 ++++++++++
 4 files changed

// File: rtl/mem_store_monitor_pkg.sv
// Shared types and trace-entry layout for the MIPS store monitor.
// Optional build macro: STORE_MON_TSTAMP_EN (adds a 32-bit cycle stamp to each entry).
package mips_mon_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } mon_state_e;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int TS_W     = 32;
  localparam int ADDR_LSB = 0;
  localparam int DATA_LSB = ADDR_LSB + ADDR_W;
  localparam int TS_LSB   = DATA_LSB + DATA_W;

`ifdef STORE_MON_TSTAMP_EN
  localparam int ENTRY_W = ADDR_W + DATA_W + TS_W;
`else
  localparam int ENTRY_W = ADDR_W + DATA_W;
`endif

endpackage

// File: rtl/mem_store_monitor_if.sv
// Store bus from the CPU plus the trace drain port of the store monitor.
// Optional build macro: STORE_MON_TSTAMP_EN (adds rd_tstamp).
interface mem_store_monitor_if;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        rd_ready;
  logic        rd_valid;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
`ifdef STORE_MON_TSTAMP_EN
  logic [31:0] rd_tstamp;
`endif

  modport master (
    output memwrite, dataadr, writedata, rd_ready,
    input  rd_valid, rd_addr, rd_data
`ifdef STORE_MON_TSTAMP_EN
    , input rd_tstamp
`endif
  );

  modport slave (
    input  memwrite, dataadr, writedata, rd_ready,
    output rd_valid, rd_addr, rd_data
`ifdef STORE_MON_TSTAMP_EN
    , output rd_tstamp
`endif
  );
endinterface

// File: rtl/mem_store_monitor_fifo.sv
// Show-ahead synchronous FIFO: head entry is visible on rdata whenever non-empty.
// A push into a full FIFO is accepted only when a pop happens at the same edge.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign count   = cnt;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // NOTE: storage array is deliberately not reset; validity is tracked by cnt,
  // and leaving it reset-free lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mem_store_monitor.sv
// Store trace logger and pass/fail/timeout judge for the single-cycle MIPS data-memory bus.
// Optional build macro: STORE_MON_TSTAMP_EN (per-entry cycle stamp on rd_tstamp).
module mem_store_monitor
  import mips_mon_pkg::*;
#(
  parameter int          DEPTH          = 16,
  parameter logic [31:0] EXPECT_ADDR    = 32'h54,
  parameter logic [31:0] EXPECT_DATA    = 32'h7,
  parameter int          TIMEOUT_CYCLES = 1000
) (
  input  logic                   clk,
  input  logic                   reset,
  mem_store_monitor_if.slave     bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   done,
  output logic                   pass,
  output logic                   fail,
  output logic                   timeout
);

  mon_state_e       state_q;
  mon_state_e       state_d;
  logic [31:0]      wd_q;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic             fifo_full;
  logic             fifo_empty;
  logic             addr_hit;
  logic             wd_expire;

`ifdef STORE_MON_TSTAMP_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clk) begin
    if (reset) cyc_q <= '0;
    else       cyc_q <= cyc_q + 32'd1;
  end

  assign push_entry    = {cyc_q, bus.writedata, bus.dataadr};
  assign bus.rd_tstamp = head_entry[TS_LSB +: TS_W];
`else
  assign push_entry = {bus.writedata, bus.dataadr};
`endif

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.memwrite),
    .pop   (bus.rd_ready),
    .wdata (push_entry),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign bus.rd_valid = ~fifo_empty;
  assign bus.rd_addr  = head_entry[ADDR_LSB +: ADDR_W];
  assign bus.rd_data  = head_entry[DATA_LSB +: DATA_W];

  // A full FIFO only drops the store when the consumer is not freeing a slot this edge.
  always_ff @(posedge clk) begin
    if (reset)                                          overflow <= 1'b0;
    else if (bus.memwrite && fifo_full && !bus.rd_ready) overflow <= 1'b1;
  end

  assign addr_hit  = bus.memwrite && (bus.dataadr == EXPECT_ADDR);
  assign wd_expire = (TIMEOUT_CYCLES != 0) && (wd_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_RUN) wd_q <= wd_q + 32'd1;
    end
  end

  // NOTE: combinational next-state logic assigns a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN) begin
      // A store to the watched address outranks watchdog expiry at the same edge.
      if (addr_hit)       state_d = (bus.writedata == EXPECT_DATA) ? ST_PASS : ST_FAIL;
      else if (wd_expire) state_d = ST_TIMEOUT;
    end
  end

  always_comb begin
    pass    = (state_q == ST_PASS);
    fail    = (state_q == ST_FAIL);
    timeout = (state_q == ST_TIMEOUT);
    done    = (state_q != ST_RUN);
  end

endmodule
